// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a framed, checksummed byte stream into
// little-endian 32-bit words, writes them to instruction memory, and holds the core until done.
module prog_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              error
);
   typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHK, DONE, ERR} state_t;

   localparam logic [7:0] SYNC  = 8'hA5;
   localparam logic [8:0] MAX_N = 9'(MAX_WORDS);

   state_t      state;
   logic [7:0]  n_words;
   logic [7:0]  word_idx;
   logic [7:0]  sum;
   logic [1:0]  byte_cnt;
   logic [23:0] low_bytes;
   logic        accept;
   logic [7:0]  sum_next;

   assign accept   = in_valid && in_ready;
   assign sum_next = sum + in_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         core_hold <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
         n_words   <= '0;
         word_idx  <= '0;
         sum       <= '0;
         byte_cnt  <= '0;
         low_bytes <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (accept && in_data == SYNC)
                  state <= LEN;
            end
            LEN: begin
               if (accept) begin
                  if (in_data == 8'h00 || {1'b0, in_data} > MAX_N) begin
                     error <= 1'b1;
                     state <= ERR;
                  end else begin
                     n_words  <= in_data;
                     word_idx <= '0;
                     byte_cnt <= '0;
                     sum      <= '0;
                     state    <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  sum      <= sum_next;
                  byte_cnt <= byte_cnt + 2'd1;
                  // Bytes enter from the top so the first byte ends up in [7:0] after three shifts.
                  if (byte_cnt == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= ADDR_W'({word_idx, 2'b00});
                     mem_wdata <= {in_data, low_bytes};
                     in_ready  <= 1'b0;
                     state     <= WRITE;
                  end else begin
                     low_bytes <= {in_data, low_bytes[23:8]};
                  end
               end
            end
            WRITE: begin
               word_idx <= word_idx + 8'd1;
               in_ready <= 1'b1;
               if ((word_idx + 8'd1) == n_words)
                  state <= CHK;
               else
                  state <= DATA;
            end
            CHK: begin
               if (accept) begin
                  if (sum_next == 8'h00) begin
                     done      <= 1'b1;
                     core_hold <= 1'b0;
                     in_ready  <= 1'b0;
                     state     <= DONE;
                  end else begin
                     error <= 1'b1;
                     state <= ERR;
                  end
               end
            end
            DONE: begin
               in_ready <= 1'b0;
            end
            ERR: begin
               if (accept && in_data == SYNC) begin
                  error <= 1'b0;
                  state <= LEN;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a frame-level model predicts memory writes and final
// status from each byte stream; a monitor compares every write strobe against it.
module tb_prog_loader;
   localparam int ADDR_W    = 8;
   localparam int MAX_WORDS = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_hold;
   logic              done;
   logic              error;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0]        stim[$];
   logic [ADDR_W-1:0] exp_addr[$];
   logic [31:0]       exp_data[$];
   logic              exp_done;
   logic              exp_err;
   logic              prev_we = 1'b0;
   int                edges;

   always #5 clk = ~clk;

   prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .core_hold(core_hold), .done(done), .error(error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Frame-level model: walk the byte list frame by frame and list the writes it implies.
   task automatic predict();
      int pos;
      int n;
      int cnt;
      bit stop;
      logic [7:0]  s;
      logic [31:0] w;
      pos = 0;
      n = stim.size();
      stop = 0;
      exp_done = 0;
      exp_err = 0;
      while (pos < n && !exp_done && !stop) begin
         if (stim[pos] != 8'hA5) begin
            pos++;
            continue;
         end
         exp_err = 0;
         pos++;
         if (pos >= n) break;
         cnt = int'(stim[pos]);
         pos++;
         if (cnt == 0 || cnt > MAX_WORDS) begin
            exp_err = 1;
            continue;
         end
         s = 8'h00;
         for (int k = 0; k < cnt && !stop; k++) begin
            if (pos + 4 > n) stop = 1;
            else begin
               w = {stim[pos+3], stim[pos+2], stim[pos+1], stim[pos]};
               s = s + stim[pos] + stim[pos+1] + stim[pos+2] + stim[pos+3];
               exp_addr.push_back(ADDR_W'(4 * k));
               exp_data.push_back(w);
               pos += 4;
            end
         end
         if (stop || pos >= n) break;
         s = s + stim[pos];
         pos++;
         if (s == 8'h00) exp_done = 1;
         else exp_err = 1;
      end
   endtask

   task automatic send_range(input int lo, input int hi, input bit gap, output int n_edges);
      int  tries;
      bit  acc;
      n_edges = 0;
      for (int i = lo; i < hi; i++) begin
         acc = 0;
         tries = 0;
         while (!acc) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = stim[i];
            acc      = in_ready;
            @(posedge clk);
            n_edges++;
            tries++;
            if (!acc && tries > 8) begin
               vectors++;
               miscompares++;
               $display("FAIL accept_timeout: byte %0d in_ready got %b required 1", i, in_ready);
               $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
               $finish;
               return;
            end
         end
         if (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'hA5;
            @(posedge clk);
            n_edges++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic check_reset_vals(input string p);
      check({p, "_in_ready"},  32'(in_ready),  32'd0);
      check({p, "_mem_we"},    32'(mem_we),    32'd0);
      check({p, "_mem_addr"},  32'(mem_addr),  32'd0);
      check({p, "_mem_wdata"}, mem_wdata,      32'd0);
      check({p, "_core_hold"}, 32'(core_hold), 32'd1);
      check({p, "_done"},      32'(done),      32'd0);
      check({p, "_error"},     32'(error),     32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      check_reset_vals("rst");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      stim.delete();
      exp_addr.delete();
      exp_data.delete();
   endtask

   task automatic finish_check(input string p);
      repeat (2) @(negedge clk);
      check({p, "_done"},      32'(done),      32'(exp_done));
      check({p, "_error"},     32'(error),     32'(exp_err));
      check({p, "_core_hold"}, 32'(core_hold), 32'(!exp_done));
      check({p, "_in_ready"},  32'(in_ready),  32'(!exp_done));
      check({p, "_pending"},   32'(exp_addr.size()), 32'd0);
      exp_addr.delete();
      exp_data.delete();
   endtask

   // Every write strobe must match the next predicted write, last one cycle and stall input.
   always @(negedge clk) begin
      if (mem_we) begin
         check("we_with_ready", 32'(in_ready), 32'd0);
         check("we_one_cycle", 32'(prev_we), 32'd0);
         if (exp_addr.size() == 0) begin
            check("unexpected_we_addr", 32'(mem_addr), 32'hFFFF_FFFF);
         end else begin
            check("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
            check("mem_wdata", mem_wdata, exp_data.pop_front());
         end
      end
      prev_we = mem_we;
   end

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;

      // Single-word frame
      do_reset();
      stim = {8'hA5, 8'h01, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h48};
      predict();
      check("model_s1_addr", 32'(exp_addr[0]), 32'h0);
      check("model_s1_word", exp_data[0], 32'h00A00513);
      check("model_s1_done", 32'(exp_done), 32'd1);
      send_range(0, 7, 1'b0, edges);
      check("s1_edges", 32'(edges), 32'd8);
      finish_check("s1");

      // Two-word frame, continuous then gapped
      do_reset();
      stim = {8'hA5, 8'h02, 8'h93, 8'h05, 8'h10, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h45};
      predict();
      check("model_s2_word0", exp_data[0], 32'h00100593);
      check("model_s2_addr1", 32'(exp_addr[1]), 32'h4);
      check("model_s2_word1", exp_data[1], 32'h00000013);
      send_range(0, 11, 1'b0, edges);
      check("s2_edges", 32'(edges), 32'd13);
      finish_check("s2");

      do_reset();
      stim = {8'hA5, 8'h02, 8'h93, 8'h05, 8'h10, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h45};
      predict();
      send_range(0, 11, 1'b1, edges);
      finish_check("s2gap");

      // Bad checksum, then recovery with the correct frame
      do_reset();
      stim = {8'hA5, 8'h01, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h49,
              8'hA5, 8'h01, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h48};
      predict();
      check("model_s3_writes", 32'(exp_addr.size()), 32'd2);
      send_range(0, 7, 1'b0, edges);
      @(negedge clk);
      check("s3_bad_error", 32'(error), 32'd1);
      check("s3_bad_done", 32'(done), 32'd0);
      check("s3_bad_hold", 32'(core_hold), 32'd1);
      send_range(7, 8, 1'b0, edges);
      check("s3_error_cleared", 32'(error), 32'd0);
      send_range(8, 14, 1'b0, edges);
      finish_check("s3");

      // Garbage before sync
      do_reset();
      stim = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h48};
      predict();
      send_range(0, 10, 1'b0, edges);
      check("s4_edges", 32'(edges), 32'd11);
      finish_check("s4");

      // Illegal and boundary lengths
      do_reset();
      stim = {8'hA5, 8'h00};
      predict();
      check("model_len0_err", 32'(exp_err), 32'd1);
      send_range(0, 2, 1'b0, edges);
      finish_check("len0");

      do_reset();
      stim = {8'hA5, 8'h41};
      predict();
      send_range(0, 2, 1'b0, edges);
      finish_check("len65");

      do_reset();
      stim = {8'hA5, 8'h40};
      predict();
      send_range(0, 2, 1'b0, edges);
      finish_check("len64");

      // Asynchronous reset mid-frame
      do_reset();
      stim = {8'hA5, 8'h01, 8'h13, 8'h05};
      predict();
      send_range(0, 4, 1'b0, edges);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_reset_vals("async");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      stim = {8'hA5, 8'h01, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h48};
      exp_addr.delete();
      exp_data.delete();
      predict();
      send_range(0, 7, 1'b0, edges);
      check("s6_edges", 32'(edges), 32'd8);
      finish_check("s6");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader for the pipelined RV64 core. It receives a framed byte stream and assembles it into 32-bit little-endian instruction words. It writes those words into instruction memory through a word-write port, which is the write side of the fetch path that `insmem` reads. It holds the core stalled, with the PC frozen, until a complete frame with a valid checksum has been written.

## Interface
- `ADDR_W`, default 8: instruction-memory byte-address width; matches the 8-bit PC.
- `MAX_WORDS`, default 64: largest accepted word count (2^ADDR_W / 4).

- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: the loader accepts `in_data` this cycle.
- `mem_we`  out  1: one-cycle word-write strobe to instruction memory.
- `mem_addr`  out  ADDR_W: byte address of the word being written; always a multiple of 4.
- `mem_wdata`  out  32: instruction word, assembled little-endian.
- `core_hold`  out  1: while high, the core is held (PC_Write=0, IF_ID_Write=0).
- `done`  out  1: image loaded and checksum verified.
- `error`  out  1: frame rejected.

## Operation
- Frame format: `0xA5` (sync), then N (word count, 1..MAX_WORDS), then 4N payload bytes with the low byte of each word first, then CHK.
- The frame is valid when (sum of payload bytes + CHK) mod 256 == 0. The sync and N bytes are not included in the sum.
- A byte is transferred on a rising edge where `in_valid && in_ready`.
- States and transitions:
  - IDLE, `in_ready`=1: `0xA5` goes to LEN. Any other byte is discarded and the state stays IDLE.
  - LEN, `in_ready`=1: N in 1..MAX_WORDS goes to DATA, clearing the word index, byte counter and running sum. N=0 or N>MAX_WORDS goes to ERR.
  - DATA, `in_ready`=1: each byte is shifted into bits [8*k+7:8*k], where k is the byte counter (0..3), and added to the 8-bit sum. On the 4th byte the state goes to WRITE.
  - WRITE, `in_ready`=0: `mem_we`=1, `mem_addr`=4*word_index (ADDR_W bits), `mem_wdata`=assembled word. After this cycle, word_index increments. If word_index+1==N the state goes to CHK, otherwise back to DATA.
  - CHK, `in_ready`=1: the accepted byte is added to the sum. A result of 0x00 goes to DONE; anything else goes to ERR.
  - DONE, `in_ready`=0: terminal until reset. `done`=1, `core_hold`=0. Input is ignored.
  - ERR, `in_ready`=1: `error`=1, `core_hold`=1. A byte `0xA5` goes to LEN and clears `error`. Other bytes are discarded.
- Words written before a checksum failure remain in memory. This is harmless because `core_hold` stays high, so the core never runs a rejected image.
- Nothing is ever written to memory outside the WRITE state.

## Timing
- Reset values: `in_ready`=0 while `reset` is high, then 1 (IDLE). `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_hold`=1, `done`=0, `error`=0.
- All outputs are decoded from registered state and registered data. No input reaches an output combinationally.
- The write strobe is asserted in the cycle after the 4th byte of a word is accepted. It lasts exactly one cycle, and `in_ready` is 0 in that cycle.
- With `in_valid` held high, throughput is 5 cycles per word. A frame takes 2 + 5N + 1 accepting cycles, and DONE or ERR is entered on the edge that accepts CHK.
- `in_valid` gaps stall the loader in its current state with no side effects. `in_data` is not sampled when `in_valid`=0.
- Reset asserted mid-frame forces every output to its reset value immediately, because the reset is asynchronous. The partial word and the sum are discarded, and memory contents are left as they are.
- `mem_addr` wraps naturally at 2^ADDR_W. The N limit makes wrap unreachable within a single frame.

## Test plan
- Single-word frame A5 01 13 05 A0 00 48 -> one `mem_we` pulse with `mem_addr`=0x00, `mem_wdata`=0x00A00513. Then `done`=1 and `core_hold`=0, 7 accept edges plus 1 write cycle after reset.
- Two-word frame A5 02 93 05 10 00 13 00 00 00 45 -> writes (0x00, 0x00100593) and (0x04, 0x00000013), then `done`=1.
  - Repeat with `in_valid` low every other cycle: same writes, same final state.
- Bad checksum: the single-word frame with CHK=0x49 -> word still written, `error`=1, `done`=0, `core_hold`=1.
  - Then send the correct frame -> `error` clears on the next `0xA5`, and `done`=1 at the end.
- Garbage before sync: 00 FF 5A, then the single-word frame -> the first three bytes cause no writes, and the result is identical to the first scenario.
- Illegal length: A5 00 -> `error`=1 with no `mem_we`. Likewise A5 41 -> `error`=1.
- Reset after A5 01 13 05 -> no `mem_we`, outputs at reset values. A fresh single-word frame then completes normally.
